// File: rtl/tnoc_input_port_controller_if.sv
// Port-control link between one router input port and its five output-port arbitrators.
// Bits are packed as port p, VC v at index p*CHANNELS+v.
interface tnoc_input_port_controller_if #(
  parameter int CHANNELS = 2
);
  logic [5*CHANNELS-1:0] request;
  logic [5*CHANNELS-1:0] start_of_packet;
  logic [5*CHANNELS-1:0] end_of_packet;
  logic [5*CHANNELS-1:0] free;
  logic [5*CHANNELS-1:0] grant;

  modport master (
    output request,
    output start_of_packet,
    output end_of_packet,
    output free,
    input  grant
  );

  modport slave (
    input  request,
    input  start_of_packet,
    input  end_of_packet,
    input  free,
    output grant
  );
endinterface

// File: rtl/tnoc_input_port_controller.sv
// Per-VC packet tracker and dimension-order router for one router input port.
// Define TNOC_YX_ROUTING_EN to resolve Y before X; default is XY routing.
module tnoc_input_port_controller #(
  parameter int CHANNELS = 2,
  parameter int X_WIDTH  = 4,
  parameter int Y_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [X_WIDTH-1:0]            i_x_id,
  input  logic [Y_WIDTH-1:0]            i_y_id,
  input  logic [CHANNELS-1:0]           i_valid,
  input  logic [CHANNELS-1:0]           i_head,
  input  logic [CHANNELS-1:0]           i_tail,
  input  logic [CHANNELS*X_WIDTH-1:0]   i_dest_x,
  input  logic [CHANNELS*Y_WIDTH-1:0]   i_dest_y,
  output logic [CHANNELS-1:0]           o_ready,
  output logic [CHANNELS*5-1:0]         o_route,
  tnoc_input_port_controller_if.master  port_if,
  output logic [CHANNELS-1:0]           o_error
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ROUTE  = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  // One-hot port order: 0 X+, 1 X-, 2 Y+, 3 Y-, 4 local.
  function automatic logic [4:0] route_decode(
    input logic [X_WIDTH-1:0] dest_x,
    input logic [Y_WIDTH-1:0] dest_y,
    input logic [X_WIDTH-1:0] x_id,
    input logic [Y_WIDTH-1:0] y_id
  );
    logic [4:0] r;
`ifdef TNOC_YX_ROUTING_EN
    if (dest_y > y_id)      r = 5'b00100;
    else if (dest_y < y_id) r = 5'b01000;
    else if (dest_x > x_id) r = 5'b00001;
    else if (dest_x < x_id) r = 5'b00010;
    else                    r = 5'b10000;
`else
    if (dest_x > x_id)      r = 5'b00001;
    else if (dest_x < x_id) r = 5'b00010;
    else if (dest_y > y_id) r = 5'b00100;
    else if (dest_y < y_id) r = 5'b01000;
    else                    r = 5'b10000;
`endif
    return r;
  endfunction

  logic [CHANNELS*5-1:0] req_all;
  logic [CHANNELS*5-1:0] sop_all;
  logic [CHANNELS*5-1:0] eop_all;

  genvar gi, gp;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_vc
      logic [1:0] state_q, state_d;
      logic [4:0] route_q, route_d;
      logic       head_pending_q, head_pending_d;
      logic [4:0] grant_v;
      logic [4:0] req_v, sop_v, eop_v;
      logic       xfer, err;

      for (gp = 0; gp < 5; gp++) begin : g_grant
        assign grant_v[gp] = port_if.grant[gp*CHANNELS+gi];
      end

      always_comb begin
        state_d        = state_q;
        route_d        = route_q;
        head_pending_d = head_pending_q;
        req_v          = '0;
        sop_v          = '0;
        eop_v          = '0;
        xfer           = 1'b0;
        err            = 1'b0;
        case (state_q)
          IDLE: begin
            if (i_valid[gi]) begin
              if (i_head[gi]) begin
                route_d = route_decode(i_dest_x[gi*X_WIDTH +: X_WIDTH],
                                       i_dest_y[gi*Y_WIDTH +: Y_WIDTH],
                                       i_x_id, i_y_id);
                state_d = ROUTE;
              end else begin
                // Stray body/tail flit: drain it so the buffer cannot stall.
                err = 1'b1;
              end
            end
          end
          ROUTE: begin
            state_d        = ACTIVE;
            head_pending_d = 1'b1;
          end
          ACTIVE: begin
            req_v = route_q & {5{i_valid[gi]}};
            sop_v = req_v & {5{head_pending_q}};
            xfer  = i_valid[gi] & |(route_q & grant_v);
            if (xfer) begin
              head_pending_d = 1'b0;
              if (i_tail[gi]) begin
                eop_v   = route_q;
                route_d = '0;
                state_d = IDLE;
              end
            end
          end
          default: begin
            state_d = IDLE;
            route_d = '0;
          end
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q        <= IDLE;
          route_q        <= '0;
          head_pending_q <= 1'b0;
        end else begin
          state_q        <= state_d;
          route_q        <= route_d;
          head_pending_q <= head_pending_d;
        end
      end

      assign req_all[gi*5 +: 5] = req_v;
      assign sop_all[gi*5 +: 5] = sop_v;
      assign eop_all[gi*5 +: 5] = eop_v;
      assign o_route[gi*5 +: 5] = route_q;
      assign o_ready[gi]        = xfer | err;
      assign o_error[gi]        = err;
    end
  endgenerate

  // Transpose per-VC groups into the port-major packing of the link.
  always_comb begin
    port_if.request         = '0;
    port_if.start_of_packet = '0;
    port_if.end_of_packet   = '0;
    port_if.free            = '0;
    for (int v = 0; v < CHANNELS; v++) begin
      for (int p = 0; p < 5; p++) begin
        port_if.request[p*CHANNELS+v]         = req_all[v*5+p];
        port_if.start_of_packet[p*CHANNELS+v] = sop_all[v*5+p];
        port_if.end_of_packet[p*CHANNELS+v]   = eop_all[v*5+p];
        port_if.free[p*CHANNELS+v]            = eop_all[v*5+p];
      end
    end
  end

endmodule

// File: tb/tb_tnoc_input_port_controller.sv
// Self-checking bench for tnoc_input_port_controller: table vectors, directed
// multi-cycle sequences and a randomized run against a transaction-level model.
module tb_tnoc_input_port_controller;
  localparam int CH = 2;
  localparam int XW = 4;
  localparam int YW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XW-1:0]   x_id;
  logic [YW-1:0]   y_id;
  logic [CH-1:0]   valid, head, tail, ready, error;
  logic [CH*XW-1:0] dest_x;
  logic [CH*YW-1:0] dest_y;
  logic [CH*5-1:0] route;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tnoc_input_port_controller_if #(.CHANNELS(CH)) pif ();

  tnoc_input_port_controller #(.CHANNELS(CH), .X_WIDTH(XW), .Y_WIDTH(YW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_x_id   (x_id),
    .i_y_id   (y_id),
    .i_valid  (valid),
    .i_head   (head),
    .i_tail   (tail),
    .i_dest_x (dest_x),
    .i_dest_y (dest_y),
    .o_ready  (ready),
    .o_route  (route),
    .port_if  (pif),
    .o_error  (error)
  );

  typedef struct {
    int         xi;
    int         yi;
    int         dx;
    int         dy;
    logic [4:0] exp_route;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid    = '0;
    head     = '0;
    tail     = '0;
    dest_x   = '0;
    dest_y   = '0;
    pif.grant = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Dimension-order routing written directly from the routing rules.
  function automatic int exp_port(input int xi, input int yi, input int dx, input int dy);
`ifdef TNOC_YX_ROUTING_EN
    if (dy > yi) return 2;
    if (dy < yi) return 3;
    if (dx > xi) return 0;
    if (dx < xi) return 1;
    return 4;
`else
    if (dx > xi) return 0;
    if (dx < xi) return 1;
    if (dy > yi) return 2;
    if (dy < yi) return 3;
    return 4;
`endif
  endfunction

  function automatic logic [CH*5-1:0] pv(input int p, input int v);
    logic [CH*5-1:0] r;
    r = '0;
    r[p*CH+v] = 1'b1;
    return r;
  endfunction

  function automatic logic [4:0] oh(input int p);
    logic [4:0] r;
    r = '0;
    r[p] = 1'b1;
    return r;
  endfunction

  // Transaction-level model state and random flit generator state.
  bit m_busy[CH];
  int m_port[CH];
  int m_act[CH];
  bit m_first[CH];
  bit g_has[CH];
  int g_len[CH];
  int g_idx[CH];
  int g_dx[CH];
  int g_dy[CH];

  initial begin
    int p, p0, p1, n_rdy, sop_late, bad_free, n_free, sop_c2, idx;
    bit got_xfer;
    logic [CH*5-1:0] m;
    logic [CH*5-1:0] e_req, e_sop, e_eop, e_route;
    logic [CH-1:0]   e_ready, e_err;
    int cyc_n;

    vecs[0] = '{2, 2, 3, 2,  5'b00001};
    vecs[1] = '{2, 2, 0, 2,  5'b00010};
    vecs[2] = '{2, 2, 2, 3,  5'b00100};
    vecs[3] = '{2, 2, 2, 0,  5'b01000};
    vecs[4] = '{2, 2, 2, 2,  5'b10000};
    vecs[9] = '{0, 15, 0, 14, 5'b01000};
`ifdef TNOC_YX_ROUTING_EN
    vecs[5] = '{1, 1, 3, 3,  5'b00100};
    vecs[6] = '{2, 2, 0, 0,  5'b01000};
    vecs[7] = '{2, 2, 15, 0, 5'b01000};
    vecs[8] = '{2, 2, 1, 15, 5'b00100};
`else
    vecs[5] = '{1, 1, 3, 3,  5'b00001};
    vecs[6] = '{2, 2, 0, 0,  5'b00010};
    vecs[7] = '{2, 2, 15, 0, 5'b00001};
    vecs[8] = '{2, 2, 1, 15, 5'b00010};
`endif

    // Reset with headers on both VCs: everything quiet, requests at cycle 2.
    x_id = 4'd1; y_id = 4'd1;
    idle_inputs();
    rst_n = 1'b0;
    #2;
    valid = '1; head = '1; tail = '0;
    dest_x = {4'd3, 4'd3}; dest_y = {4'd0, 4'd0};
    pif.grant = '1;
    @(negedge clk);
    check("rst_ready",   32'(ready), 0);
    check("rst_error",   32'(error), 0);
    check("rst_request", 32'(pif.request), 0);
    check("rst_sop",     32'(pif.start_of_packet), 0);
    check("rst_eop",     32'(pif.end_of_packet), 0);
    check("rst_free",    32'(pif.free), 0);
    check("rst_route",   32'(route), 0);
    tick();
    rst_n = 1'b1;
    pif.grant = '0;
    @(negedge clk);
    check("rel_c0_request", 32'(pif.request), 0);
    tick();
    @(negedge clk);
    check("rel_c1_request", 32'(pif.request), 0);
    tick();
    p = exp_port(1, 1, 3, 0);
    @(negedge clk);
    check("rel_c2_request", 32'(pif.request), 32'(pv(p, 0) | pv(p, 1)));
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_request", 32'(pif.request), 0);
    check("midrst_route",   32'(route), 0);
    check("midrst_free",    32'(pif.free), 0);
    tick();
    apply_reset();

    // Single-flit packet on VC0, id(1,1) dest(3,0).
    x_id = 4'd1; y_id = 4'd1;
    valid = 2'b01; head = 2'b01; tail = 2'b01;
    dest_x = {4'd0, 4'd3}; dest_y = {4'd0, 4'd0};
    p = exp_port(1, 1, 3, 0);
    for (int c = 0; c <= 4; c++) begin
      pif.grant = (c == 4) ? pv(p, 0) : '0;
      @(negedge clk);
      if (c < 2) begin
        check($sformatf("sf_c%0d_request", c), 32'(pif.request), 0);
        check($sformatf("sf_c%0d_ready", c), 32'(ready), 0);
      end
      if (c == 1) check("sf_c1_route", 32'(route[4:0]), 32'(oh(p)));
      if (c == 2 || c == 3) begin
        check($sformatf("sf_c%0d_request", c), 32'(pif.request), 32'(pv(p, 0)));
        check($sformatf("sf_c%0d_sop", c), 32'(pif.start_of_packet), 32'(pv(p, 0)));
        check($sformatf("sf_c%0d_ready", c), 32'(ready), 0);
      end
      if (c == 4) begin
        check("sf_c4_ready", 32'(ready), 1);
        check("sf_c4_eop",   32'(pif.end_of_packet), 32'(pv(p, 0)));
        check("sf_c4_free",  32'(pif.free), 32'(pv(p, 0)));
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    check("sf_c5_route",   32'(route), 0);
    check("sf_c5_request", 32'(pif.request), 0);
    tick();

    // 4-flit local packet on VC1 with grant every other cycle.
    dest_x = {4'd1, 4'd0}; dest_y = {4'd1, 4'd0};
    idx = 0; n_rdy = 0; sop_late = 0; bad_free = 0; n_free = 0; sop_c2 = 0; got_xfer = 0;
    for (int c = 0; c < 16; c++) begin
      valid = (idx < 4) ? 2'b10 : 2'b00;
      head  = (idx == 0) ? 2'b10 : 2'b00;
      tail  = (idx == 3) ? 2'b10 : 2'b00;
      pif.grant = (c >= 2 && (c % 2) == 1) ? pv(4, 1) : '0;
      @(negedge clk);
      if (c == 2 && pif.start_of_packet == pv(4, 1)) sop_c2 = 1;
      if (got_xfer && pif.start_of_packet != '0) sop_late++;
      if (pif.free != '0) begin
        n_free++;
        if (idx != 3 || pif.free != pv(4, 1)) bad_free++;
      end
      if (ready[1]) begin
        n_rdy++;
        idx++;
        got_xfer = 1;
      end
      tick();
    end
    check("p4_sop_at_c2",   32'(sop_c2), 1);
    check("p4_ready_count", 32'(n_rdy), 4);
    check("p4_sop_late",    32'(sop_late), 0);
    check("p4_free_count",  32'(n_free), 1);
    check("p4_free_wrong",  32'(bad_free), 0);
    idle_inputs();

    // VC0 to X-, VC1 to Y+ concurrently; port-2 grant for VC0 is ignored.
    dest_x = {4'd1, 4'd0}; dest_y = {4'd2, 4'd1};
    p0 = exp_port(1, 1, 0, 1);
    p1 = exp_port(1, 1, 1, 2);
    m = pv(p0, 0) | pv(p1, 1);
    valid = 2'b11; head = 2'b11; tail = 2'b00;
    tick();
    tick();
    pif.grant = pv(2, 0);
    @(negedge clk);
    check("dual_c2_ready",   32'(ready), 0);
    check("dual_c2_request", 32'(pif.request), 32'(m));
    tick();
    pif.grant = m;
    @(negedge clk);
    check("dual_c3_ready", 32'(ready), 3);
    check("dual_c3_sop",   32'(pif.start_of_packet), 32'(m));
    check("dual_c3_eop",   32'(pif.end_of_packet), 0);
    tick();
    head = 2'b00; tail = 2'b11;
    @(negedge clk);
    check("dual_c4_ready", 32'(ready), 3);
    check("dual_c4_sop",   32'(pif.start_of_packet), 0);
    check("dual_c4_eop",   32'(pif.end_of_packet), 32'(m));
    check("dual_c4_free",  32'(pif.free), 32'(m));
    tick();
    idle_inputs();
    @(negedge clk);
    check("dual_c5_route", 32'(route), 0);
    tick();

    // Non-header flit in IDLE on VC1.
    valid = 2'b10; head = 2'b00; tail = 2'b10;
    @(negedge clk);
    check("err_ready",   32'(ready), 2);
    check("err_error",   32'(error), 2);
    check("err_request", 32'(pif.request), 0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("err_clear", 32'(error), 0);
    tick();

    // Routing table on VC0.
    foreach (vecs[i]) begin
      logic [CH*5-1:0] exp_req;
      exp_req = '0;
      for (int q = 0; q < 5; q++) exp_req[q*CH] = vecs[i].exp_route[q];
      x_id = 4'(vecs[i].xi); y_id = 4'(vecs[i].yi);
      dest_x = {4'd0, 4'(vecs[i].dx)}; dest_y = {4'd0, 4'(vecs[i].dy)};
      valid = 2'b01; head = 2'b01; tail = 2'b01;
      tick();
      @(negedge clk);
      check($sformatf("tbl%0d_route", i), 32'(route[4:0]), 32'(vecs[i].exp_route));
      tick();
      @(negedge clk);
      check($sformatf("tbl%0d_request", i), 32'(pif.request), 32'(exp_req));
      pif.grant = '1;
      #1;
      check($sformatf("tbl%0d_ready", i), 32'(ready), 1);
      check($sformatf("tbl%0d_free", i), 32'(pif.free), 32'(exp_req));
      tick();
      idle_inputs();
      @(negedge clk);
      check($sformatf("tbl%0d_idle", i), 32'(route), 0);
      tick();
    end

    // Randomized traffic against the transaction-level model.
    apply_reset();
    x_id = 4'd1; y_id = 4'd2;
    for (int v = 0; v < CH; v++) begin
      m_busy[v] = 0; m_port[v] = 0; m_act[v] = 0; m_first[v] = 0;
      g_has[v] = 0; g_len[v] = 0; g_idx[v] = 0; g_dx[v] = 0; g_dy[v] = 0;
    end
    cyc_n = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int v = 0; v < CH; v++) begin
        if (!g_has[v]) begin
          int r;
          r = int'($urandom_range(0, 7));
          g_dx[v] = int'($urandom_range(0, 3));
          g_dy[v] = int'($urandom_range(0, 3));
          if (r == 0) begin
            valid[v] = 1'b1; head[v] = 1'b0; tail[v] = 1'($urandom_range(0, 1));
          end else if (r <= 4) begin
            g_has[v] = 1; g_len[v] = r; g_idx[v] = 0;
          end else begin
            valid[v] = 1'b0; head[v] = 1'b0; tail[v] = 1'b0;
          end
        end
        if (g_has[v]) begin
          valid[v] = ($urandom_range(0, 3) != 0);
          head[v]  = (g_idx[v] == 0);
          tail[v]  = (g_idx[v] == g_len[v] - 1);
        end
        dest_x[v*XW +: XW] = 4'(g_dx[v]);
        dest_y[v*YW +: YW] = 4'(g_dy[v]);
      end
      pif.grant = 10'($urandom_range(0, 1023));
      @(negedge clk);
      e_req = '0; e_sop = '0; e_eop = '0; e_route = '0; e_ready = '0; e_err = '0;
      for (int v = 0; v < CH; v++) begin
        if (!m_busy[v]) begin
          if (valid[v] && !head[v]) begin
            e_ready[v] = 1'b1;
            e_err[v]   = 1'b1;
          end else if (valid[v] && head[v]) begin
            m_busy[v]  = 1;
            m_port[v]  = exp_port(1, 2, g_dx[v], g_dy[v]);
            m_act[v]   = cyc_n + 2;
            m_first[v] = 1;
          end
        end else begin
          e_route[v*5 + m_port[v]] = 1'b1;
          if (cyc_n >= m_act[v] && valid[v]) begin
            e_req[m_port[v]*CH+v] = 1'b1;
            if (m_first[v]) e_sop[m_port[v]*CH+v] = 1'b1;
            if (pif.grant[m_port[v]*CH+v]) begin
              e_ready[v] = 1'b1;
              m_first[v] = 0;
              if (tail[v]) begin
                e_eop[m_port[v]*CH+v] = 1'b1;
                m_busy[v] = 0;
              end
            end
          end
        end
      end
      check($sformatf("rnd%0d_ready", t),   32'(ready), 32'(e_ready));
      check($sformatf("rnd%0d_error", t),   32'(error), 32'(e_err));
      check($sformatf("rnd%0d_request", t), 32'(pif.request), 32'(e_req));
      check($sformatf("rnd%0d_sop", t),     32'(pif.start_of_packet), 32'(e_sop));
      check($sformatf("rnd%0d_eop", t),     32'(pif.end_of_packet), 32'(e_eop));
      check($sformatf("rnd%0d_free", t),    32'(pif.free), 32'(e_eop));
      check($sformatf("rnd%0d_route", t),   32'(route), 32'(e_route));
      for (int v = 0; v < CH; v++) begin
        if (g_has[v] && e_ready[v]) begin
          g_idx[v]++;
          if (g_idx[v] == g_len[v]) g_has[v] = 0;
        end
      end
      tick();
      cyc_n++;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
